fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch side of the multicycle CPU. Owns the PC, drives the IMem address port, latches the returned word into the IR, and presents it to the datapath through a valid/ack handshake.
- On ack it resolves the next PC: sequential, jump, or BEQ/BNE/BLT/BLE using register operands supplied by the register file.
- Sits between IMem and the control/datapath.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset (word address).
- FETCH_WAIT, 0, extra wait cycles in FETCH before the IR capture (0..15).
- BR_RELATIVE, 0, 0: branch target = zero-extended imm[15:0] (absolute word address); 1: target = PC+1+sign-extended imm[15:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  word address to IMem; always equals the PC register.
- imem_data  in  32  instruction word from IMem (combinational in address).
- ir  out  32  latched instruction.
- ir_valid  out  1  ir holds an instruction not yet acknowledged.
- ir_ack  in  1  datapath has completed the instruction; sampled only while ir_valid=1.
- ra_sel  out  5  ir[25:21], register file read select A.
- rb_sel  out  5  ir[20:16], register file read select B.
- ra_val  in  32  R[ra_sel], valid in the ack cycle.
- rb_val  in  32  R[rb_sel], valid in the ack cycle.
- halt  in  1  stop fetching after the current instruction.
- halted  out  1  FSM is in HALT.
- retired  out  32  count of acknowledged instructions.

Behaviour:
- Reset is asynchronous active-low, one clock.
- Reset values: pc=RESET_PC, ir=0, ir_valid=0, halted=0, retired=0, wait counter=0, state=FETCH.
- FSM states: FETCH, ISSUE, HALT.
- FETCH:
  - Wait counter counts 0..FETCH_WAIT.
  - On the cycle the count equals FETCH_WAIT: ir<=imem_data, ir_valid<=1, go to ISSUE, counter reset to 0.
  - With FETCH_WAIT=0, FETCH lasts exactly 1 cycle.
- ISSUE:
  - ir_valid=1; ir and pc are held stable.
  - On a rising edge with ir_ack=1: pc<=next_pc, ir_valid<=0, retired<=retired+1 (wraps 0xFFFFFFFF->0).
  - Then go to HALT if halt=1 in that cycle, else to FETCH.
- Minimum throughput: 2+FETCH_WAIT cycles per instruction.
- next_pc, decoded on opcode ir[31:26]:
  - 000001 J: {6'b0, ir[25:0]}.
  - 100000 BEQ: taken if ra_val==rb_val.
  - 100001 BNE: taken if ra_val!=rb_val.
  - 100010 BLT: taken if signed ra_val<rb_val.
  - 100011 BLE: taken if signed ra_val<=rb_val.
  - Branch taken: branch target per BR_RELATIVE. Branch not taken, and all other opcodes (including NOOP 0): pc+1.
- All PC arithmetic is 32-bit modulo; pc 0xFFFFFFFF +1 -> 0.
- halt:
  - Sampled only in the ISSUE ack cycle and while in HALT. Asserting halt during FETCH does not abort that fetch.
  - HALT: halted=1, ir_valid=0, pc holds next_pc. When halt=0, go to FETCH next cycle; halted drops in the same edge.
- ir_ack while ir_valid=0 is ignored and causes no state change.
- ra_sel/rb_sel are combinational from ir; they change only when ir is loaded.
- Reset asserted mid-operation (any state) immediately forces the reset values; any pending instruction is discarded and retired is not incremented.
- ir_valid never asserts in the same cycle that rst_n is low.

Test Plan:
- Reset release, IMem returns 0 for addr 0 -> imem_addr=0; ir_valid=1 at edge 1 with ir=0; ack at edge 2 -> imem_addr=1, retired=1, ir_valid=0; next ir_valid at edge 3.
- pc=15, ir=0x810D0011 (BEQ r8,r13,17), BR_RELATIVE=0: ra_val=rb_val=0xA, ack -> imem_addr=17. Repeat with rb_val=0 -> imem_addr=16.
- BLT ra_val=0xFFFFFFFF, rb_val=1 -> taken. BLE ra_val=rb_val=5 -> taken. BNE equal operands -> pc+1. BR_RELATIVE=1, pc=6, imm=0xFFFD, BLT taken -> imem_addr=4.
- ir=0x04000000 (J 0) at pc=26 -> imem_addr=0. A non-branch at pc=0xFFFFFFFF -> imem_addr=0.
- FETCH_WAIT=2: ir_valid rises exactly 3 cycles after entering FETCH. Hold ir_ack=0 for 5 cycles -> ir and imem_addr stable, retired unchanged.
- halt=1 during the ack cycle -> halted=1, no fetch, ir_valid=0; release halt -> fetch resumes at next_pc. Pull rst_n low mid-ISSUE -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer for the multicycle CPU.
// Owns the PC, addresses IMem, captures the returned word into the IR and
// hands it to the datapath. Once the datapath acknowledges, the next PC is
// chosen: sequential, jump, or a conditional branch on the register operands.
//
// Handshake: ir_valid=1 means ir holds an instruction the datapath has not yet
// completed. ir and pc stay frozen while ir_valid=1. The instruction is
// consumed on the rising edge where ir_valid=1 and ir_ack=1. ir_ack is ignored
// whenever ir_valid=0.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter int unsigned FETCH_WAIT  = 0,
    parameter bit          BR_RELATIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        ir_ack,
    output logic [4:0]  ra_sel,
    output logic [4:0]  rb_sel,
    input  logic [31:0] ra_val,
    input  logic [31:0] rb_val,
    input  logic        halt,
    output logic        halted,
    output logic [31:0] retired,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_ISSUE = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [5:0] OP_J   = 6'b000001;
    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_BNE = 6'b100001;
    localparam logic [5:0] OP_BLT = 6'b100010;
    localparam logic [5:0] OP_BLE = 6'b100011;

    // Last value of the fetch wait counter; the IR is captured on that cycle.
    localparam logic [3:0] WAIT_LAST = FETCH_WAIT[3:0];

    state_t      state;
    logic [31:0] pc;
    logic [3:0]  wait_cnt;

    logic [5:0]  opcode;
    logic [15:0] imm;
    logic [31:0] br_target;
    logic        br_taken;
    logic [31:0] next_pc;

    assign imem_addr = pc;
    assign ra_sel    = ir[25:21];
    assign rb_sel    = ir[20:16];
    assign state_dbg = state;

    assign opcode = ir[31:26];
    assign imm    = ir[15:0];

    // Branch target: absolute zero-extended word address, or PC-relative to
    // the following instruction with a sign-extended offset.
    always_comb begin
        br_target = {16'b0, imm};
        if (BR_RELATIVE) begin
            br_target = pc + 32'd1 + {{16{imm[15]}}, imm};
        end
    end

    // Resolve the PC that follows the instruction currently held in the IR.
    always_comb begin
        br_taken = 1'b0;
        next_pc  = pc + 32'd1;
        case (opcode)
            OP_J:    next_pc  = {6'b0, ir[25:0]};
            OP_BEQ:  br_taken = (ra_val == rb_val);
            OP_BNE:  br_taken = (ra_val != rb_val);
            OP_BLT:  br_taken = ($signed(ra_val) <  $signed(rb_val));
            OP_BLE:  br_taken = ($signed(ra_val) <= $signed(rb_val));
            default: br_taken = 1'b0;
        endcase
        if (br_taken) begin
            next_pc = br_target;
        end
    end

    // Fetch / issue / halt sequencing with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= 32'd0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
            retired  <= 32'd0;
            wait_cnt <= 4'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (wait_cnt == WAIT_LAST) begin
                        ir       <= imem_data;
                        ir_valid <= 1'b1;
                        wait_cnt <= 4'd0;
                        state    <= S_ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_ISSUE: begin
                    if (ir_ack) begin
                        pc       <= next_pc;
                        ir_valid <= 1'b0;
                        retired  <= retired + 32'd1;
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            state  <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    if (!halt) begin
                        halted <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (FETCH_WAIT=0 absolute branches,
// FETCH_WAIT=2 relative branches), a transaction-level reference model, a
// per-cycle compare process and directed programs with literal expectations.
module tb_fetch_sequencer;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUT wiring ----------------
    logic [1:0][31:0] addr_w, ir_w, ret_w, idata, ra, rb;
    logic [1:0][4:0]  ras_w, rbs_w;
    logic [1:0][1:0]  st_w;
    logic [1:0]       valid_w, halted_w, ack, hlt;

    logic [31:0] imem0 [64];
    logic [31:0] imem1 [64];

    assign idata[0] = imem0[addr_w[0][5:0]];
    assign idata[1] = imem1[addr_w[1][5:0]];

    fetch_sequencer #(.RESET_PC(32'd0), .FETCH_WAIT(0), .BR_RELATIVE(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr_w[0]), .imem_data(idata[0]),
        .ir(ir_w[0]), .ir_valid(valid_w[0]), .ir_ack(ack[0]),
        .ra_sel(ras_w[0]), .rb_sel(rbs_w[0]), .ra_val(ra[0]), .rb_val(rb[0]),
        .halt(hlt[0]), .halted(halted_w[0]), .retired(ret_w[0]), .state_dbg(st_w[0])
    );

    fetch_sequencer #(.RESET_PC(32'd0), .FETCH_WAIT(2), .BR_RELATIVE(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr_w[1]), .imem_data(idata[1]),
        .ir(ir_w[1]), .ir_valid(valid_w[1]), .ir_ack(ack[1]),
        .ra_sel(ras_w[1]), .rb_sel(rbs_w[1]), .ra_val(ra[1]), .rb_val(rb[1]),
        .halt(hlt[1]), .halted(halted_w[1]), .retired(ret_w[1]), .state_dbg(st_w[1])
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int fw(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic bit rel(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic [31:0] mem_rd(input int i, input logic [31:0] a);
        return (i == 0) ? imem0[a[5:0]] : imem1[a[5:0]];
    endfunction

    // Where the program goes after retiring instr at pc.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] instr,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input bit r);
        int op;
        bit taken;
        logic [31:0] target;
        op = int'(instr[31:26]);
        if (op == 1) return {6'b0, instr[25:0]};
        taken = 1'b0;
        if (op == 32) taken = (a == b);
        if (op == 33) taken = (a != b);
        if (op == 34) taken = ($signed(a) <  $signed(b));
        if (op == 35) taken = ($signed(a) <= $signed(b));
        if (r) target = pc + 32'd1 + 32'($signed(instr[15:0]));
        else   target = 32'(instr[15:0]);
        return taken ? target : pc + 32'd1;
    endfunction

    logic [31:0] m_pc [2];
    logic [31:0] m_ir [2];
    logic [31:0] m_ret [2];
    bit          m_valid [2];
    bit          m_halted [2];
    int          m_wait [2];

    // Model: an instruction waits fw() extra cycles to arrive, then sits until
    // acknowledged; acknowledged instructions advance pc and count.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_pc[i] = 32'd0; m_ir[i] = 32'd0; m_ret[i] = 32'd0;
                m_valid[i] = 1'b0; m_halted[i] = 1'b0; m_wait[i] = 0;
            end else if (m_halted[i]) begin
                if (!hlt[i]) m_halted[i] = 1'b0;
            end else if (m_valid[i]) begin
                if (ack[i]) begin
                    m_pc[i]    = model_next(m_pc[i], m_ir[i], ra[i], rb[i], rel(i));
                    m_valid[i] = 1'b0;
                    m_ret[i]   = m_ret[i] + 32'd1;
                    if (hlt[i]) m_halted[i] = 1'b1;
                end
            end else if (m_wait[i] == fw(i)) begin
                m_ir[i]    = mem_rd(i, m_pc[i]);
                m_valid[i] = 1'b1;
                m_wait[i]  = 0;
            end else begin
                m_wait[i] = m_wait[i] + 1;
            end
        end
    end

    // Compare every output of both instances on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("cyc%0d_addr", i),    addr_w[i],            m_pc[i]);
                chk($sformatf("cyc%0d_ir", i),      ir_w[i],              m_ir[i]);
                chk($sformatf("cyc%0d_valid", i),   32'(valid_w[i]),      32'(m_valid[i]));
                chk($sformatf("cyc%0d_halted", i),  32'(halted_w[i]),     32'(m_halted[i]));
                chk($sformatf("cyc%0d_retired", i), ret_w[i],             m_ret[i]);
                chk($sformatf("cyc%0d_rasel", i),   32'(ras_w[i]),        32'(m_ir[i][25:21]));
                chk($sformatf("cyc%0d_rbsel", i),   32'(rbs_w[i]),        32'(m_ir[i][20:16]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_valid(input int i);
        int n;
        n = 0;
        while (!valid_w[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_valid%0d", i), 32'(valid_w[i]), 32'd1);
    endtask

    // Acknowledge the pending instruction with the given operands and halt.
    task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic h);
        wait_valid(i);
        ack[i] = 1'b1;
        ra[i]  = a;
        rb[i]  = b;
        hlt[i] = h;
        @(negedge clk);
        ack[i] = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        ack = '0; hlt = '0; ra = '0; rb = '0;
        for (int k = 0; k < 64; k++) begin
            imem0[k] = 32'd0;
            imem1[k] = 32'd0;
        end
        imem0[1]  = 32'h0400000F;  // J 15
        imem0[15] = 32'h810D0011;  // BEQ r8,r13,17
        imem0[17] = 32'h0400000F;  // J 15
        imem0[16] = 32'h88000014;  // BLT -> 20
        imem0[20] = 32'h8C000018;  // BLE -> 24
        imem0[24] = 32'h8400001A;  // BNE -> 26
        imem0[25] = 32'h0400001A;  // J 26
        imem0[26] = 32'h04000000;  // J 0
        imem1[0]  = 32'h04000006;  // J 6
        imem1[6]  = 32'h8800FFFD;  // BLT pc+1-3
        imem1[4]  = 32'h8800FFFA;  // BLT pc+1-6 -> 0xFFFFFFFF
        imem1[63] = 32'h00000000;  // NOOP at 0xFFFFFFFF (aliased)

        repeat (3) @(negedge clk);
        chk("rst_addr",    addr_w[0],        32'd0);
        chk("rst_valid",   32'(valid_w),     32'd0);
        chk("rst_ir",      ir_w[0],          32'd0);
        chk("rst_retired", ret_w[0],         32'd0);
        chk("rst_halted",  32'(halted_w),    32'd0);
        rst_n = 1'b1;

        // Edge 1: A captures NOOP; B still waiting.
        @(negedge clk);
        chk("e1_valid_a", 32'(valid_w[0]), 32'd1);
        chk("e1_ir_a",    ir_w[0],         32'd0);
        chk("e1_addr_a",  addr_w[0],       32'd0);
        chk("e1_valid_b", 32'(valid_w[1]), 32'd0);
        ack[0] = 1'b1;
        // Edge 2: A retires, pc=1.
        @(negedge clk);
        ack[0] = 1'b0;
        chk("e2_addr_a",    addr_w[0],       32'd1);
        chk("e2_retired_a", ret_w[0],        32'd1);
        chk("e2_valid_a",   32'(valid_w[0]), 32'd0);
        chk("e2_valid_b",   32'(valid_w[1]), 32'd0);
        // Edge 3: A has J 15; B captures after 3 cycles of FETCH.
        @(negedge clk);
        chk("e3_valid_a", 32'(valid_w[0]), 32'd1);
        chk("e3_ir_a",    ir_w[0],         32'h0400000F);
        chk("e3_valid_b", 32'(valid_w[1]), 32'd1);
        chk("e3_ir_b",    ir_w[1],         32'h04000006);

        issue(0, 32'd0, 32'd0, 1'b0);
        chk("j15_addr", addr_w[0], 32'd15);
        wait_valid(0);
        chk("beq_rasel", 32'(ras_w[0]), 32'd8);
        chk("beq_rbsel", 32'(rbs_w[0]), 32'd13);
        issue(0, 32'hA, 32'hA, 1'b0);
        chk("beq_taken", addr_w[0], 32'd17);
        issue(0, 32'd0, 32'd0, 1'b0);
        issue(0, 32'hA, 32'd0, 1'b0);
        chk("beq_not_taken", addr_w[0], 32'd16);
        issue(0, 32'hFFFFFFFF, 32'd1, 1'b0);
        chk("blt_signed", addr_w[0], 32'd20);
        issue(0, 32'd5, 32'd5, 1'b0);
        chk("ble_equal", addr_w[0], 32'd24);
        issue(0, 32'd7, 32'd7, 1'b0);
        chk("bne_equal", addr_w[0], 32'd25);
        issue(0, 32'd0, 32'd0, 1'b0);
        chk("j26_addr", addr_w[0], 32'd26);
        issue(0, 32'd0, 32'd0, 1'b0);
        chk("j0_addr", addr_w[0], 32'd0);

        // Halt on the ack of the NOOP at 0.
        issue(0, 32'd0, 32'd0, 1'b1);
        chk("halt_halted",  32'(halted_w[0]), 32'd1);
        chk("halt_valid",   32'(valid_w[0]),  32'd0);
        chk("halt_addr",    addr_w[0],        32'd1);
        chk("halt_retired", ret_w[0],         32'd11);
        ack[0] = 1'b1;
        repeat (3) @(negedge clk);
        ack[0] = 1'b0;
        chk("halt_hold_addr",    addr_w[0], 32'd1);
        chk("halt_hold_retired", ret_w[0],  32'd11);
        hlt[0] = 1'b0;
        @(negedge clk);
        chk("resume_halted", 32'(halted_w[0]), 32'd0);
        chk("resume_valid",  32'(valid_w[0]),  32'd0);
        @(negedge clk);
        chk("resume_valid2", 32'(valid_w[0]),  32'd1);
        chk("resume_ir",     ir_w[0],          32'h0400000F);

        // Asynchronous reset in the middle of a low clock phase during ISSUE.
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_addr",    addr_w[0],       32'd0);
        chk("arst_ir",      ir_w[0],         32'd0);
        chk("arst_valid",   32'(valid_w),    32'd0);
        chk("arst_retired", ret_w[0],        32'd0);
        chk("arst_halted",  32'(halted_w),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Instance B: hold ack low for 5 cycles, nothing may move.
        wait_valid(1);
        repeat (5) @(negedge clk);
        chk("hold_ir_b",      ir_w[1],         32'h04000006);
        chk("hold_addr_b",    addr_w[1],       32'd0);
        chk("hold_retired_b", ret_w[1],        32'd0);
        chk("hold_valid_b",   32'(valid_w[1]), 32'd1);
        issue(1, 32'd0, 32'd0, 1'b0);
        chk("b_j6", addr_w[1], 32'd6);
        issue(1, 32'hFFFFFFFF, 32'd1, 1'b0);
        chk("b_rel_back", addr_w[1], 32'd4);
        issue(1, 32'hFFFFFFFF, 32'd1, 1'b0);
        chk("b_rel_top", addr_w[1], 32'hFFFFFFFF);
        issue(1, 32'd0, 32'd0, 1'b0);
        chk("b_wrap", addr_w[1], 32'd0);
        chk("b_retired", ret_w[1], 32'd4);

        // ack and halt during FETCH are ignored; the fetch still completes.
        ack[1] = 1'b1;
        hlt[1] = 1'b1;
        @(negedge clk);
        ack[1] = 1'b0;
        hlt[1] = 1'b0;
        chk("fetch_halt_ignored", 32'(halted_w[1]), 32'd0);
        chk("fetch_ack_valid",    32'(valid_w[1]),  32'd0);
        @(negedge clk);
        chk("fetch_wait_valid",   32'(valid_w[1]),  32'd0);
        @(negedge clk);
        chk("fetch_done_valid",   32'(valid_w[1]),  32'd1);
        chk("fetch_done_ir",      ir_w[1],          32'h04000006);
        chk("fetch_done_retired", ret_w[1],         32'd4);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
